// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: stage write enables, bubble inserts and
// branch-predict clear for a 5-stage pipeline with a multi-cycle divider.
module pipe_ctrl #(
   parameter int unsigned DIV_LAT = 17
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_reg_j,
   input  logic [4:0]  id_reg_k,
   input  logic [4:0]  id_reg_d,
   input  logic        id_reg_j_ren,
   input  logic        id_reg_k_ren,
   input  logic        id_reg_d_ren,
   input  logic        ex_is_load,
   input  logic [4:0]  ex_reg_d,
   input  logic        ex_div_start,
   input  logic        ex_br_mispredict,
   input  logic        wb_exception,
   input  logic        icache_miss,
   input  logic        dcache_miss,
   output logic        pc_wen,
   output logic        if_id_wen,
   output logic        id_ex_wen,
   output logic        ex_mem_wen,
   output logic        mem_wb_wen,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        mem_wb_flush,
   output logic        bp_flush,
   output logic [1:0]  ctrl_state,
   output logic [31:0] stall_cycles
);

   localparam int unsigned CNT_W  = 6;
   localparam int unsigned STAT_W = 32;

   localparam logic [1:0] ST_RUN = 2'd0;
   localparam logic [1:0] ST_DIV = 2'd1;
   localparam logic [1:0] ST_EXC = 2'd2;

   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
   logic [STAT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic              load_use_c;
   logic              is_run_c;

   // Load-use hazard: EX load writes a register an enabled ID source reads.
   always_comb begin
      load_use_c = ex_is_load && (ex_reg_d != 5'd0) &&
                   ((id_reg_j_ren && (id_reg_j == ex_reg_d)) ||
                    (id_reg_k_ren && (id_reg_k == ex_reg_d)) ||
                    (id_reg_d_ren && (id_reg_d == ex_reg_d)));
      // The unused encoding behaves as RUN and is steered back to RUN.
      is_run_c   = (state_q == ST_RUN) || (state_q == 2'd3);
   end

   // Prioritised event decode: stage controls plus FSM/counter next state.
   always_comb begin
      pc_wen       = 1'b1;
      if_id_wen    = 1'b1;
      id_ex_wen    = 1'b1;
      ex_mem_wen   = 1'b1;
      mem_wb_wen   = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      bp_flush     = 1'b0;
      state_d      = is_run_c ? ST_RUN : state_q;
      div_cnt_d    = div_cnt_q;

      if (!rst_n) begin
         pc_wen     = 1'b0;
         if_id_wen  = 1'b0;
         id_ex_wen  = 1'b0;
         ex_mem_wen = 1'b0;
         mem_wb_wen = 1'b0;
      end else if (wb_exception || (state_q == ST_EXC)) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
         mem_wb_flush = 1'b1;
         bp_flush     = 1'b1;
         state_d      = wb_exception ? ST_EXC : ST_RUN;
         div_cnt_d    = '0;
      end else if (dcache_miss) begin
         pc_wen     = 1'b0;
         if_id_wen  = 1'b0;
         id_ex_wen  = 1'b0;
         ex_mem_wen = 1'b0;
         mem_wb_wen = 1'b0;
      end else if ((state_q == ST_DIV) || (is_run_c && ex_div_start)) begin
         pc_wen       = 1'b0;
         if_id_wen    = 1'b0;
         id_ex_wen    = 1'b0;
         ex_mem_wen   = 1'b0;
         mem_wb_flush = 1'b1;
         if (is_run_c) begin
            state_d   = ST_DIV;
            div_cnt_d = DIV_LOAD;
         end else if (div_cnt_q <= CNT_W'(1)) begin
            state_d   = ST_RUN;
            div_cnt_d = '0;
         end else begin
            div_cnt_d = div_cnt_q - CNT_W'(1);
         end
      end else if (ex_br_mispredict) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         bp_flush    = 1'b1;
      end else if (load_use_c) begin
         pc_wen      = 1'b0;
         if_id_wen   = 1'b0;
         id_ex_flush = 1'b1;
      end else if (icache_miss) begin
         pc_wen      = 1'b0;
         if_id_flush = 1'b1;
      end
   end

   // Saturating count of cycles in which the PC did not advance.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!pc_wen && (stall_cycles_q != {STAT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + STAT_W'(1);
      end
   end

   // State, divider countdown and stall counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_RUN;
         div_cnt_q      <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         div_cnt_q      <= div_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign ctrl_state   = state_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: DIV_LAT, default 17, total divider stall cycles; legal range 2..63.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 id_reg_j / id_reg_k / id_reg_d  in  5 each  source register indices of the instruction in ID.
REQ-005 id_reg_j_ren / id_reg_k_ren / id_reg_d_ren  in  1 each  per-source read enables for the ID instruction.
REQ-006 ex_is_load  in  1  the EX instruction is a load.
REQ-007 ex_reg_d  in  5  destination register index of the EX instruction.
REQ-008 ex_div_start  in  1  a divide/modulo enters EX this cycle.
REQ-009 ex_br_mispredict  in  1  the branch resolved in EX was mispredicted.
REQ-010 wb_exception  in  1  exception or ertn committing in WB.
REQ-011 icache_miss / dcache_miss  in  1 each  fetch wait / memory-stage wait.
REQ-012 pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1 each  stage write enables.
REQ-013 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  stage bubble inserts.
REQ-014 bp_flush  out  1  clears the predicted-branch flag entering ID/EX.
REQ-015 ctrl_state  out  2  FSM state: RUN=0, DIV=1, EXC=2.
REQ-016 stall_cycles  out  32  count of cycles with pc_wen=0.

Function
REQ-017 FSM states RUN, DIV and EXC; encoding 3 is unreachable and SHALL return to RUN on the next cycle.
REQ-018 Default in RUN with no event: all wen=1, all flush=0, bp_flush=0.
REQ-019 Events are evaluated in this priority order: exception, dcache_miss, DIV state or div start, mispredict, load-use, icache_miss.
REQ-020 Exception (wb_exception=1, any state): all wen=1, all four flushes=1, bp_flush=1.
REQ-021 Exception state update: next state EXC, div counter cleared to 0, so an in-flight divide is aborted.
REQ-022 EXC state: outputs identical to REQ-020 for exactly 1 cycle, then RUN.
REQ-023 dcache_miss (no exception): all wen=0, all flush=0, bp_flush=0.
REQ-024 During dcache_miss the FSM state and div counter SHALL hold.
REQ-025 Div start (ex_div_start=1 in RUN): next state DIV, counter loaded with DIV_LAT-1.
REQ-026 Div stall (start cycle and every DIV cycle): pc/if_id/id_ex/ex_mem wen=0, mem_wb_wen=1, mem_wb_flush=1.
REQ-027 DIV counter: decrements each non-frozen DIV cycle; DIV with counter=1 goes to RUN next cycle; total stall = DIV_LAT cycles.
REQ-028 Mispredict (RUN, no higher event): all wen=1, if_id_flush=1, id_ex_flush=1, bp_flush=1; any load-use or icache_miss stall that cycle is suppressed.
REQ-029 Load-use hazard: ex_is_load=1, ex_reg_d!=0, and an enabled ID source equals ex_reg_d.
REQ-030 Load-use response: pc_wen=0, if_id_wen=0, id_ex_wen=1 with id_ex_flush=1, all other wen=1.
REQ-031 icache_miss alone: pc_wen=0, if_id_wen=1 with if_id_flush=1, all other wen=1.
REQ-032 icache_miss together with load-use: the load-use response wins, and IF/ID holds.
REQ-033 A mispredict arriving during DIV is ignored by the controller; EX holds it and it is serviced on the first RUN cycle.
REQ-034 stall_cycles increments in every cycle with pc_wen=0, saturates at 0xFFFFFFFF and never wraps.
REQ-035 All wen/flush outputs are combinational from the current state and inputs.

Reset
REQ-036 While rst_n=0: all wen=0, all flush=0, bp_flush=0.
REQ-037 On the first clock edge with rst_n=0: state RUN, counter 0, stall_cycles 0.
REQ-038 Reset asserted mid-DIV or mid-EXC SHALL abort to RUN with no residual stall after release.

Verification
REQ-039 Load-use: ex_is_load=1, ex_reg_d=5, id_reg_j=5, j_ren=1 -> pc_wen=0, if_id_wen=0, id_ex_flush=1 for 1 cycle; stall_cycles +1.
REQ-040 Divide: DIV_LAT=17, ex_div_start pulse -> exactly 17 cycles of pc_wen=0 with mem_wb_flush=1, then RUN.
REQ-041 Exception mid-DIV (cycle 5): all flush=1 and bp_flush=1 for 2 cycles (event cycle + EXC), then RUN with no remaining div stall.
REQ-042 dcache_miss for 3 cycles during DIV: all wen=0 those cycles, counter frozen; total div stall 17+3 cycles.
REQ-043 Mispredict together with load-use and icache_miss: if_id_flush=1, id_ex_flush=1, bp_flush=1, pc_wen=1.
REQ-044 stall_cycles preloaded to 0xFFFFFFFE, then 3 stall cycles -> value reads 0xFFFFFFFF.
